// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the register file and its busy scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_if.sv
// Register file bus: read ports, writeback, issue and hazard outputs.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);

    logic [NUM_RD*ADDR_W-1:0] rdAdr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdBusy;
    logic                     wrEn;
    logic [ADDR_W-1:0]        wrAdr;
    logic [DATA_W-1:0]        wrData;
    logic                     issueEn;
    logic [ADDR_W-1:0]        issueAdr;
    logic [ADDR_W:0]          pendingCnt;

    modport master (
        output rdAdr, wrEn, wrAdr, wrData, issueEn, issueAdr,
        input  rdData, rdBusy, pendingCnt
    );

    modport slave (
        input  rdAdr, wrEn, wrAdr, wrData, issueEn, issueAdr,
        output rdData, rdBusy, pendingCnt
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, zero-register override and write-through bypass.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [DATA_W-1:0]      regs_in [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]   busy_in,
    input  logic [ADDR_W-1:0]      rd_adr,
    input  logic                   fwd_en,
    input  logic [ADDR_W-1:0]      wr_adr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_busy
);

    logic is_zero;
    logic fwd_hit;

    // The zero register wins over everything, including a forwarded write.
    always_comb begin
        is_zero = (ZERO_REG != 0) && (rd_adr == ADDR_W'(REG_ZERO));
        fwd_hit = (BYPASS != 0) && fwd_en && (wr_adr == rd_adr);
        rd_data = regs_in[rd_adr];
        rd_busy = busy_in[rd_adr];
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (fwd_hit) begin
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass and a per-register busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        regs_d [DEPTH];
    logic [DEPTH-1:0]         busy_q;
    logic [DEPTH-1:0]         busy_d;
    logic [ADDR_W:0]          pending_cnt_q;
    logic [ADDR_W:0]          pending_cnt_d;
    logic                     wr_ok;
    logic                     issue_ok;
    logic                     cnt_inc;
    logic                     cnt_dec;
    logic [NUM_RD*DATA_W-1:0] rd_data_all;
    logic [NUM_RD-1:0]        rd_busy_all;

    // A writeback clears busy unless the same register is re-issued this cycle.
    always_comb begin
        wr_ok    = bus.wrEn &&
                   !((ZERO_REG != 0) && (bus.wrAdr == ADDR_W'(REG_ZERO)));
        issue_ok = bus.issueEn &&
                   !((ZERO_REG != 0) && (bus.issueAdr == ADDR_W'(REG_ZERO)));
        cnt_inc  = issue_ok && !busy_q[bus.issueAdr];
        cnt_dec  = wr_ok && busy_q[bus.wrAdr] &&
                   !(issue_ok && (bus.issueAdr == bus.wrAdr));

        regs_d        = regs_q;
        busy_d        = busy_q;
        pending_cnt_d = pending_cnt_q;
        if (wr_ok) begin
            regs_d[bus.wrAdr] = bus.wrData;
            busy_d[bus.wrAdr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[bus.issueAdr] = 1'b1;
        end
        case ({cnt_inc, cnt_dec})
            2'b10:   pending_cnt_d = pending_cnt_q + (ADDR_W+1)'(1);
            2'b01:   pending_cnt_d = pending_cnt_q - (ADDR_W+1)'(1);
            default: pending_cnt_d = pending_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
            busy_q        <= '0;
            pending_cnt_q <= '0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    // Forwarding is suppressed during reset so every read shows zero.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .regs_in  (regs_q),
            .busy_in  (busy_q),
            .rd_adr   (bus.rdAdr[i*ADDR_W +: ADDR_W]),
            .fwd_en   (bus.wrEn && !rst),
            .wr_adr   (bus.wrAdr),
            .wr_data  (bus.wrData),
            .rd_data  (rd_data_all[i*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy_all[i])
        );
    end

    assign bus.rdData     = rd_data_all;
    assign bus.rdBusy     = rd_busy_all;
    assign bus.pendingCnt = pending_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: reference model feeds an expectation queue.
module tb_regfile_scoreboard;

    import regfile_pkg::*;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } expect_t;

    logic clk;
    logic rst;

    regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    regfile_scoreboard #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mRegs [32];
    bit          mBusy [32];
    expect_t     sbQ [$];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            passes++;
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int a = 0; a < 32; a++) n += int'(mBusy[a]);
        return n;
    endfunction

    task automatic modelReset();
        for (int a = 0; a < 32; a++) begin
            mRegs[a] = '0;
            mBusy[a] = 1'b0;
        end
    endtask

    // Expected view of one read port given the model and the inputs being driven now.
    task automatic pushPort(input string tag, input int port, input logic [4:0] adr);
        logic [31:0] expData;
        logic        expBusy;
        if (adr == 5'd0) begin
            expData = '0;
            expBusy = 1'b0;
        end else if (bus.wrEn && bus.wrAdr == adr) begin
            expData = bus.wrData;
            expBusy = 1'b0;
        end else begin
            expData = mRegs[adr];
            expBusy = mBusy[adr];
        end
        sbQ.push_back('{$sformatf("%s.rdData%0d", tag, port), port*2,     expData});
        sbQ.push_back('{$sformatf("%s.rdBusy%0d", tag, port), port*2 + 1, {31'b0, expBusy}});
    endtask

    task automatic drainQueue();
        expect_t     e;
        logic [31:0] obs;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            case (e.sel)
                0:       obs = bus.rdData[31:0];
                1:       obs = {31'b0, bus.rdBusy[0]};
                2:       obs = bus.rdData[63:32];
                3:       obs = {31'b0, bus.rdBusy[1]};
                default: obs = 32'(bus.pendingCnt);
            endcase
            checkOutput(e.tag, obs, e.exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, then advance model with the edge.
    task automatic applyStimulus(input string tag,
                                 input logic [4:0] rd0, input logic [4:0] rd1,
                                 input logic wen, input logic [4:0] wadr, input logic [31:0] wdata,
                                 input logic ien, input logic [4:0] iadr);
        bus.rdAdr    = {rd1, rd0};
        bus.wrEn     = wen;
        bus.wrAdr    = wadr;
        bus.wrData   = wdata;
        bus.issueEn  = ien;
        bus.issueAdr = iadr;
        #1;
        pushPort(tag, 0, rd0);
        pushPort(tag, 1, rd1);
        sbQ.push_back('{$sformatf("%s.pendingCnt", tag), 4, 32'(modelCount())});
        #2;
        drainQueue();
        @(posedge clk);
        if (wen && wadr != 5'd0) begin
            mRegs[wadr] = wdata;
            mBusy[wadr] = 1'b0;
        end
        if (ien && iadr != 5'd0) mBusy[iadr] = 1'b1;
        #1;
    endtask

    task automatic idleRead(input string tag, input logic [4:0] rd0, input logic [4:0] rd1);
        applyStimulus(tag, rd0, rd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.rdAdr    = '0;
        bus.wrEn     = 1'b0;
        bus.wrAdr    = '0;
        bus.wrData   = '0;
        bus.issueEn  = 1'b0;
        bus.issueAdr = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int a = 0; a < 32; a++) begin
            idleRead("reset_scan", 5'(a), 5'(31 - a));
        end

        applyStimulus("bypass_r5", 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        idleRead("hold_r5", 5'd5, 5'd0);

        applyStimulus("wr_r0", 5'd0, 5'd5, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
        applyStimulus("issue_r0", 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        idleRead("after_r0", 5'd0, 5'd5);

        applyStimulus("issue_r3", 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        applyStimulus("issue_r7", 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        idleRead("busy_r3r7", 5'd3, 5'd7);
        applyStimulus("wb_r3", 5'd3, 5'd7, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
        idleRead("after_wb_r3", 5'd3, 5'd7);

        applyStimulus("issue_r9", 5'd9, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        applyStimulus("issue_wb_r9", 5'd9, 5'd7, 1'b1, 5'd9, 32'hAA, 1'b1, 5'd9);
        idleRead("after_r9", 5'd9, 5'd3);
        applyStimulus("reissue_r9", 5'd9, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        applyStimulus("wb_nonbusy_r3", 5'd3, 5'd9, 1'b1, 5'd3, 32'h66, 1'b0, 5'd0);

        applyStimulus("setup_r2", 5'd2, 5'd9, 1'b1, 5'd2, 32'h77, 1'b1, 5'd2);
        idleRead("busy_r2", 5'd2, 5'd9);

        // Mid-cycle reset pulse with a write pending: everything must read zero at once.
        rst          = 1'b1;
        bus.rdAdr    = {5'd7, 5'd2};
        bus.wrEn     = 1'b1;
        bus.wrAdr    = 5'd2;
        bus.wrData   = 32'h99;
        #1;
        sbQ.push_back('{"rst_mid.rdData0", 0, 32'h0});
        sbQ.push_back('{"rst_mid.rdBusy0", 1, 32'h0});
        sbQ.push_back('{"rst_mid.rdData1", 2, 32'h0});
        sbQ.push_back('{"rst_mid.pendingCnt", 4, 32'h0});
        drainQueue();
        #3;
        bus.wrEn = 1'b0;
        rst      = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        idleRead("post_rst", 5'd2, 5'd9);

        for (int n = 0; n < 300; n++) begin
            applyStimulus("rand",
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
